// File: rtl/vga2_pkg.sv
// rtl/vga2_pkg.sv - shared pixel type and constants for the VGA2 Z fetch path
//
// Purpose: pixel_t carries every rasterised pixel field that travels from the
// rasteriser through the Z fetch buffer to the Z-check stage.
// Ports: none (package).
package vga2_pkg;

  // Bytes per stored Z value in the Z-buffer.
  localparam int ZBYTES = 2;

  typedef struct packed {
    logic [9:0]  x;
    logic [11:0] z;
    logic [11:0] u;
    logic [11:0] v;
    logic [4:0]  mode;
    logic [31:0] src_addr;
    logic [31:0] src_stride;
  } pixel_t;

endpackage

// File: rtl/vga2_zfetch_buf.sv
// rtl/vga2_zfetch_buf.sv - pending-pixel storage for the Z fetch scheduler
//
// Purpose: DEPTH entries of pixel_t plus fetched Z, each with an occupied
// flag and a zok flag (Z has returned).
// Ports:
//   clock, reset               - clock, asynchronous active-high reset
//   wr_en/wr_ptr/wr_pix        - park a newly accepted pixel, clear its zok
//   rsp_en/rsp_ptr/rsp_z       - store returned Z, set zok
//   rd_en/rd_ptr               - free the entry at rd_ptr (dequeue)
//   rd_pix/rd_z/rd_occ/rd_zok  - contents of the entry at rd_ptr
//   occupied, ent_x            - per-entry occupancy and x for hazard compares
module vga2_zfetch_buf
  import vga2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_ptr,
  input  pixel_t                 wr_pix,
  input  logic                   rsp_en,
  input  logic [AW-1:0]          rsp_ptr,
  input  logic [11:0]            rsp_z,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_ptr,
  output pixel_t                 rd_pix,
  output logic [11:0]            rd_z,
  output logic                   rd_occ,
  output logic                   rd_zok,
  output logic [DEPTH-1:0]       occupied,
  output logic [DEPTH-1:0][9:0]  ent_x
);

  pixel_t           pix_q [DEPTH];
  pixel_t           pix_d [DEPTH];
  logic [11:0]      z_q   [DEPTH];
  logic [11:0]      z_d   [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] zok_q, zok_d;

  // The write entry is always free and the response entry is always an
  // already-parked one, so the three ports never target the same flag bit in
  // a conflicting way; dequeue is applied first so a write wins on wrap.
  always_comb begin
    pix_d = pix_q;
    z_d   = z_q;
    occ_d = occ_q;
    zok_d = zok_q;
    if (rd_en) begin
      occ_d[rd_ptr] = 1'b0;
    end
    if (wr_en) begin
      pix_d[wr_ptr] = wr_pix;
      occ_d[wr_ptr] = 1'b1;
      zok_d[wr_ptr] = 1'b0;
    end
    if (rsp_en) begin
      z_d[rsp_ptr]   = rsp_z;
      zok_d[rsp_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pix_q[i] <= '0;
        z_q[i]   <= '0;
      end
      occ_q <= '0;
      zok_q <= '0;
    end else begin
      pix_q <= pix_d;
      z_q   <= z_d;
      occ_q <= occ_d;
      zok_q <= zok_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_x[i] = pix_q[i].x;
    end
  end

  assign rd_pix   = pix_q[rd_ptr];
  assign rd_z     = z_q[rd_ptr];
  assign rd_occ   = occ_q[rd_ptr];
  assign rd_zok   = zok_q[rd_ptr];
  assign occupied = occ_q;

endmodule

// File: rtl/vga2_zfetch.sv
// rtl/vga2_zfetch.sv - Z-buffer fetch scheduler in front of the Z-check stage
//
// Purpose: issues one Z read per accepted pixel, parks the pixel in order
// until its Z returns, then presents pixel plus fetched_z downstream.
// Optional build macro: VGA2_ZHAZARD_EN stalls a pixel whose column already
// has a parked pixel (same-column read-after-write protection).
// Ports:
//   clock, reset                     - clock, asynchronous active-high reset
//   zbuf_addr                        - byte address of current Z-buffer row
//   in_valid/in_ready, in_*          - pixel input handshake and fields
//   zrd_req/zrd_ready/zrd_addr       - Z read request port
//   zrd_rvalid/zrd_rdata             - in-order Z read responses
//   chkz_valid/chkz_ready, chkz_*    - downstream handshake and pixel fields
//   fetched_z                        - Z read back for the presented pixel
//   busy                             - any entry occupied
module vga2_zfetch
  import vga2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] zbuf_addr,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [9:0]  in_x,
  input  logic [11:0] in_z,
  input  logic [11:0] in_u,
  input  logic [11:0] in_v,
  input  logic [4:0]  in_mode,
  input  logic [31:0] in_src_addr,
  input  logic [31:0] in_src_stride,
  output logic        zrd_req,
  input  logic        zrd_ready,
  output logic [31:0] zrd_addr,
  input  logic        zrd_rvalid,
  input  logic [15:0] zrd_rdata,
  output logic        chkz_valid,
  input  logic        chkz_ready,
  output logic [9:0]  chkz_x,
  output logic [11:0] chkz_z,
  output logic [11:0] chkz_u,
  output logic [11:0] chkz_v,
  output logic [4:0]  chkz_mode,
  output logic [31:0] chkz_src_addr,
  output logic [31:0] chkz_src_stride,
  output logic [11:0] fetched_z,
  output logic        busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   out_q, out_d;

  logic                  full, hazard, accept, rsp_hit, deq;
  logic                  rd_occ, rd_zok;
  logic [DEPTH-1:0]      occupied;
  logic [DEPTH-1:0][9:0] ent_x;
  logic [11:0]           rd_z;
  pixel_t                in_pix, rd_pix;
  logic                  unused_bits;

  assign in_pix = '{x: in_x, z: in_z, u: in_u, v: in_v, mode: in_mode,
                    src_addr: in_src_addr, src_stride: in_src_stride};

  // Full is taken from the registered count only, so a same-cycle dequeue
  // never opens a slot; this keeps chkz_ready out of the in_ready path.
  assign full     = (occ_q == CNT_FULL);
  assign zrd_addr = zbuf_addr + 32'(in_x) * 32'(ZBYTES);
  assign zrd_req  = in_valid && !full && !hazard;
  assign in_ready = zrd_ready && !full && !hazard;
  assign accept   = in_valid && in_ready;
  // Responses with nothing outstanding (e.g. left over from before a reset)
  // are dropped.
  assign rsp_hit  = zrd_rvalid && (out_q != '0);
  assign deq      = chkz_valid && chkz_ready;

`ifdef VGA2_ZHAZARD_EN
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (ent_x[i] == in_x)) begin
        hazard = 1'b1;
      end
    end
  end
  assign unused_bits = ^zrd_rdata[15:12];
`else
  assign hazard      = 1'b0;
  assign unused_bits = ^{ent_x, zrd_rdata[15:12]};
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rsp_ptr_d = rsp_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    out_d     = out_q;
    if (accept)  wr_ptr_d  = wr_ptr_q + PTR_ONE;
    if (rsp_hit) rsp_ptr_d = rsp_ptr_q + PTR_ONE;
    if (deq)     rd_ptr_d  = rd_ptr_q + PTR_ONE;
    case ({accept, deq})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
    case ({accept, rsp_hit})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      out_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      out_q     <= out_d;
    end
  end

  vga2_zfetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (accept),
    .wr_ptr   (wr_ptr_q),
    .wr_pix   (in_pix),
    .rsp_en   (rsp_hit),
    .rsp_ptr  (rsp_ptr_q),
    .rsp_z    (zrd_rdata[11:0]),
    .rd_en    (deq),
    .rd_ptr   (rd_ptr_q),
    .rd_pix   (rd_pix),
    .rd_z     (rd_z),
    .rd_occ   (rd_occ),
    .rd_zok   (rd_zok),
    .occupied (occupied),
    .ent_x    (ent_x)
  );

  assign chkz_valid      = rd_occ && rd_zok;
  assign chkz_x          = rd_pix.x;
  assign chkz_z          = rd_pix.z;
  assign chkz_u          = rd_pix.u;
  assign chkz_v          = rd_pix.v;
  assign chkz_mode       = rd_pix.mode;
  assign chkz_src_addr   = rd_pix.src_addr;
  assign chkz_src_stride = rd_pix.src_stride;
  assign fetched_z       = rd_z;
  assign busy            = |occupied;

endmodule

// File: tb/tb_vga2_zfetch.sv
// tb/tb_vga2_zfetch.sv - self-checking bench for vga2_zfetch
`timescale 1ns/1ps
module tb_vga2_zfetch;
  import vga2_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] zbuf_addr;
  logic        in_ready, in_valid;
  logic [9:0]  in_x;
  logic [11:0] in_z, in_u, in_v;
  logic [4:0]  in_mode;
  logic [31:0] in_src_addr, in_src_stride;
  logic        zrd_req, zrd_ready, zrd_rvalid;
  logic [31:0] zrd_addr;
  logic [15:0] zrd_rdata;
  logic        chkz_valid, chkz_ready;
  logic [9:0]  chkz_x;
  logic [11:0] chkz_z, chkz_u, chkz_v, fetched_z;
  logic [4:0]  chkz_mode;
  logic [31:0] chkz_src_addr, chkz_src_stride;
  logic        busy;

  always #5 clock = ~clock;

  vga2_zfetch #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .zbuf_addr(zbuf_addr),
    .in_ready(in_ready), .in_valid(in_valid), .in_x(in_x), .in_z(in_z),
    .in_u(in_u), .in_v(in_v), .in_mode(in_mode), .in_src_addr(in_src_addr),
    .in_src_stride(in_src_stride), .zrd_req(zrd_req), .zrd_ready(zrd_ready),
    .zrd_addr(zrd_addr), .zrd_rvalid(zrd_rvalid), .zrd_rdata(zrd_rdata),
    .chkz_valid(chkz_valid), .chkz_ready(chkz_ready), .chkz_x(chkz_x),
    .chkz_z(chkz_z), .chkz_u(chkz_u), .chkz_v(chkz_v), .chkz_mode(chkz_mode),
    .chkz_src_addr(chkz_src_addr), .chkz_src_stride(chkz_src_stride),
    .fetched_z(fetched_z), .busy(busy)
  );

  typedef struct { pixel_t pix; logic [11:0] fz; } exp_t;
  typedef struct {
    logic valid; logic [31:0] base; logic [9:0] x; logic zready;
    logic [31:0] exp_addr; logic exp_in_ready; logic exp_req;
  } vec_t;

  exp_t        exp_q[$];
  logic [11:0] rsp_q[$];
  vec_t        vecs[6];
  int          checks = 0, failures = 0, acc_cnt = 0;
  bit          auto_rsp = 1'b0;
  logic [75:0] hold;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction

  task automatic set_pix(input logic [9:0] x, input logic [11:0] z);
    in_x = x; in_z = z;
    in_u = 12'($urandom); in_v = 12'($urandom); in_mode = 5'($urandom);
    in_src_addr = $urandom; in_src_stride = $urandom;
    in_valid = 1'b1;
  endtask

  // One clock: score handshakes at the negedge, advance, then drive the
  // automatic memory response for the next cycle.
  task automatic tick();
    exp_t        e;
    pixel_t      got;
    logic [11:0] tmp;
    @(negedge clock);
    if (zrd_rvalid && rsp_q.size() > 0) tmp = rsp_q.pop_front();
    if (in_valid && in_ready) begin
      e.pix = '{x: in_x, z: in_z, u: in_u, v: in_v, mode: in_mode,
                src_addr: in_src_addr, src_stride: in_src_stride};
      e.fz  = in_z + 12'h100;
      exp_q.push_back(e);
      rsp_q.push_back(e.fz);
      acc_cnt++;
    end
    if (chkz_valid && chkz_ready) begin
      got = '{x: chkz_x, z: chkz_z, u: chkz_u, v: chkz_v, mode: chkz_mode,
              src_addr: chkz_src_addr, src_stride: chkz_src_stride};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL chkz_out unexpected pixel x=%0d", chkz_x);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.pix || fetched_z !== e.fz) begin
          failures++;
          $display("FAIL chkz_out got pix=%h fz=%h want pix=%h fz=%h", got, fetched_z, e.pix, e.fz);
        end
      end
    end
    @(posedge clock); #1;
    if (auto_rsp) begin
      if (rsp_q.size() > 0) begin
        zrd_rvalid = 1'b1; zrd_rdata = {4'h0, rsp_q[0]};
      end else begin
        zrd_rvalid = 1'b0;
      end
    end
  endtask

  task automatic rsp_tick();
    if (rsp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL rsp_tick no outstanding read in model");
    end else begin
      zrd_rvalid = 1'b1; zrd_rdata = {4'h0, rsp_q[0]};
    end
    tick();
    zrd_rvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0; chkz_ready = 1'b1; auto_rsp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_busy"}, {31'b0, busy}, 0);
    auto_rsp = 1'b0; zrd_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a0;
    zbuf_addr = 32'h1000; in_valid = 0; in_x = 0; in_z = 0; in_u = 0; in_v = 0;
    in_mode = 0; in_src_addr = 0; in_src_stride = 0; zrd_ready = 1'b0;
    zrd_rvalid = 1'b0; zrd_rdata = '0; chkz_ready = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_1000, 10'd5,     1'b1, 32'h0000_100A, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_1000, 10'd5,     1'b0, 32'h0000_100A, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'hFFFF_FFFE, 10'd1,     1'b1, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0000, 10'd1023,  1'b1, 32'h0000_07FE, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h1234_5678, 10'h200,   1'b0, 32'h1234_5A78, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_2000, 10'd3,     1'b1, 32'h0000_2006, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_chkz_valid", {31'b0, chkz_valid}, 0);
    chk("rst_zrd_req",    {31'b0, zrd_req}, 0);
    chk("rst_busy",       {31'b0, busy}, 0);
    chk("rst_fetched_z",  {20'b0, fetched_z}, 0);
    chk("rst_chkz_x",     {22'b0, chkz_x}, 0);

    // Combinational address / ready vectors, never held across an edge
    foreach (vecs[i]) begin
      in_valid = vecs[i].valid; zbuf_addr = vecs[i].base; in_x = vecs[i].x;
      zrd_ready = vecs[i].zready;
      #1;
      chk($sformatf("vec%0d_addr", i), zrd_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_in_ready});
      chk($sformatf("vec%0d_zrd_req", i), {31'b0, zrd_req}, {31'b0, vecs[i].exp_req});
      in_valid = 1'b0;
      tick();
    end

    // Single pixel, minimum latency
    zbuf_addr = 32'h1000; zrd_ready = 1'b1; chkz_ready = 1'b1; auto_rsp = 1'b1;
    set_pix(10'd5, 12'h100);
    #1 chk("single_addr", zrd_addr, 32'h100A);
    tick();
    in_valid = 1'b0;
    chk("single_c1_valid", {31'b0, chkz_valid}, 0);
    tick();
    chk("single_c2_valid", {31'b0, chkz_valid}, 1);
    chk("single_fetched_z", {20'b0, fetched_z}, 32'h200);
    chk("single_chkz_z", {20'b0, chkz_z}, 32'h100);
    drain("single");

    // Backpressure fill
    chkz_ready = 1'b0; auto_rsp = 1'b1; a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      set_pix(10'(i), 12'h300 + 12'(i));
      if (i >= 4) begin
        #1;
        chk($sformatf("fill%0d_in_ready", i), {31'b0, in_ready}, 0);
        chk($sformatf("fill%0d_zrd_req", i), {31'b0, zrd_req}, 0);
      end
      tick();
    end
    chk("fill_accepted", acc_cnt - a0, 4);
    in_valid = 1'b0;
    tick(); tick();
    chk("fill_head_valid", {31'b0, chkz_valid}, 1);
    chk("fill_head_x", {22'b0, chkz_x}, 0);
    hold = {chkz_x, chkz_z, chkz_u, chkz_v, chkz_mode, fetched_z, chkz_src_addr[12:0]};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({chkz_x, chkz_z, chkz_u, chkz_v, chkz_mode, fetched_z, chkz_src_addr[12:0]} !== hold) begin
        failures++;
        $display("FAIL stall_hold%0d got x=%0d fz=%h want x=%0d", i, chkz_x, fetched_z, hold[75:66]);
      end
    end
    drain("fill");

    // Delayed responses
    chkz_ready = 1'b1; auto_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pix(10'd10 + 10'(i), 12'h0A0 + 12'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("delay_wait%0d", i), {31'b0, chkz_valid}, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) chk($sformatf("delay_out%0d", k - 1), {31'b0, chkz_valid}, 1);
      rsp_tick();
    end
    chk("delay_out2", {31'b0, chkz_valid}, 1);
    tick();
    chk("delay_done_busy", {31'b0, busy}, 0);

    // Accept, response and dequeue in the same cycle
    chkz_ready = 1'b0; auto_rsp = 1'b0; a0 = acc_cnt;
    set_pix(10'd20, 12'h020);
    tick();
    set_pix(10'd21, 12'h021);
    rsp_tick();
    chk("simul_pre_valid", {31'b0, chkz_valid}, 1);
    chk("simul_pre_occ", 32'(dut.occ_q), 2);
    chk("simul_pre_out", 32'(dut.out_q), 1);
    set_pix(10'd22, 12'h022);
    chkz_ready = 1'b1;
    rsp_tick();
    in_valid = 1'b0; chkz_ready = 1'b0;
    chk("simul_accepted", acc_cnt - a0, 3);
    chk("simul_post_occ", 32'(dut.occ_q), 2);
    chk("simul_post_out", 32'(dut.out_q), 1);
    rsp_tick();
    drain("simul");

    // Same-column hazard
    chkz_ready = 1'b0; auto_rsp = 1'b1;
    set_pix(10'd7, 12'h070);
    tick();
    set_pix(10'd7, 12'h071);
    #1;
`ifdef VGA2_ZHAZARD_EN
    chk("hz_c1_in_ready", {31'b0, in_ready}, 0);
    chk("hz_c1_zrd_req", {31'b0, zrd_req}, 0);
    tick();
    chk("hz_c2_zrd_req", {31'b0, zrd_req}, 0);
    chkz_ready = 1'b1;
    tick();
    chk("hz_c3_zrd_req", {31'b0, zrd_req}, 1);
    chk("hz_c3_in_ready", {31'b0, in_ready}, 1);
`else
    chk("hz_off_in_ready", {31'b0, in_ready}, 1);
    chk("hz_off_zrd_req", {31'b0, zrd_req}, 1);
`endif
    tick();
    drain("hazard");

    // Reset with three entries pending
    chkz_ready = 1'b0; auto_rsp = 1'b0;
    set_pix(10'd30, 12'h030);
    tick();
    set_pix(10'd31, 12'h031);
    rsp_tick();
    set_pix(10'd32, 12'h032);
    tick();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", {31'b0, chkz_valid}, 1);
    chk("rstmid_pre_busy", {31'b0, busy}, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_valid", {31'b0, chkz_valid}, 0);
    chk("rstmid_busy", {31'b0, busy}, 0);
    exp_q.delete(); rsp_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    zrd_rvalid = 1'b1; zrd_rdata = 16'h0ABC;
    tick();
    zrd_rvalid = 1'b0;
    chk("stray_out", 32'(dut.out_q), 0);
    chk("stray_valid", {31'b0, chkz_valid}, 0);
    chkz_ready = 1'b1; auto_rsp = 1'b1;
    set_pix(10'd40, 12'h040);
    tick();
    in_valid = 1'b0;
    drain("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga2_zfetch.md
# vga2_zfetch

Z-buffer fetch scheduler sitting directly in front of the 2-bit VGA Z-check stage. Accepts rasterised pixels and issues one Z-buffer read per pixel to the memory read port. Parks each pixel in a small in-order buffer until its Z value returns, then presents the pixel together with `fetched_z` to the Z-check stage under a valid/ready handshake. Bounds outstanding reads to the buffer depth and optionally stalls same-column read-after-write hazards.

## Interface
- `DEPTH`, default 4: pending-pixel buffer entries and the maximum number of outstanding reads; power of two, 2..16.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `zbuf_addr` input 32: byte address of the current Z-buffer row; quasi-static while `busy`.
- `in_ready` output 1: pixel accepted this cycle when high together with `in_valid`.
- `in_valid` input 1: pixel request valid.
- `in_x` input 10, `in_z` input 12, `in_u` input 12, `in_v` input 12, `in_mode` input 5, `in_src_addr` input 32, `in_src_stride` input 32: pixel fields.
- `zrd_req` output 1: Z read request.
- `zrd_ready` input 1: memory accepts the request this cycle.
- `zrd_addr` output 32: read byte address.
- `zrd_rvalid` input 1: read data returned; responses arrive in request order.
- `zrd_rdata` input 16: Z halfword; bits [11:0] used.
- `chkz_valid` output 1, `chkz_ready` input 1: downstream handshake.
- `chkz_x`, `chkz_z`, `chkz_u`, `chkz_v`, `chkz_mode`, `chkz_src_addr`, `chkz_src_stride` outputs: the same widths as the matching `in_*` fields.
- `fetched_z` output 12: stored Z for the presented pixel.
- `busy` output 1: high when any entry is occupied.

## Operation
- `zrd_addr = zbuf_addr + {21'b0, in_x, 1'b0}`: 2 bytes per Z, 32-bit modulo wrap.
- `zrd_req = in_valid && !full && !hazard`.
- `in_ready = zrd_ready && !full && !hazard`.
- Accept means `in_valid && in_ready`. On accept, the pixel fields are written at `wr_ptr`, the entry's `zok` flag is cleared, and `wr_ptr` increments.
- A request is never issued without its pixel being stored in the same cycle.
- On `zrd_rvalid` with `outstanding != 0`, `zrd_rdata[11:0]` is written to the entry at `rsp_ptr`, `zok` is set, and `rsp_ptr` increments.
- A `zrd_rvalid` with `outstanding == 0` is dropped. This covers stray responses after reset.
- `chkz_valid = occupied[rd_ptr] && zok[rd_ptr]`. All `chkz_*` outputs and `fetched_z` are driven from the `rd_ptr` entry.
- Dequeue on `chkz_valid && chkz_ready`: the entry is freed and `rd_ptr` increments.
- Pointers are log2(DEPTH) bits and wrap naturally. `full` and `empty` come from an occupancy counter of log2(DEPTH)+1 bits.
- The occupancy counter changes by +1 on accept, -1 on dequeue, and 0 when both happen in the same cycle.
- `outstanding` changes by +1 on accept and -1 on a counted response.

## Timing
- Reset values: all pointers and counters 0; `occupied` and `zok` all 0.
- Outputs out of reset: `chkz_valid=0`, `zrd_req=0`, `busy=0`. Data outputs are don't-care, but tests expect them at 0.
- Minimum latency: accept in cycle 0; response at the earliest in cycle 1; `chkz_valid` high in cycle 2, because `zok` is registered.
- While `chkz_valid && !chkz_ready`, all `chkz_*` outputs and `fetched_z` hold stable.
- `full` is evaluated before any same-cycle dequeue, so a full buffer does not accept even when a dequeue happens in that cycle. This is a conservative choice that removes the combinational ready path.
- A response and a dequeue of the same entry in the same cycle cannot happen, since `zok` must be set first.
- A response, an accept and a dequeue may all occur in one cycle; every counter update is applied.
- Reset asserted mid-operation discards all entries immediately, with no drain.

## Configuration
- `VGA2_ZHAZARD_EN` defined:
  - `hazard` is high when any occupied entry holds the same `x` as `in_x`.
  - A second pixel in the same column therefore waits until the earlier one has left the buffer, so it does not read a stale Z value.
- `VGA2_ZHAZARD_EN` undefined: `hazard` is tied to 0, and the comparators and associated logic are removed.

## Structure
- Shared package `vga2_pkg` holds:
  - a `pixel_t` packed struct with fields `x`, `z`, `u`, `v`, `mode`, `src_addr` and `src_stride`;
  - the constant `ZBYTES = 2`.
- One sub-module, `vga2_zfetch_buf`: the DEPTH-entry storage holding `pixel_t` plus `z` and the `occupied`/`zok` flags, with write, response and read ports. It also exposes the per-entry `x` values for the hazard compare.

## Test plan
- **Single pixel:** `zbuf_addr=0x1000`, `in_x=5`, `in_z=0x100`; response `0x0200` one cycle later.
  - Required: `zrd_addr=0x100A`; `chkz_valid` two cycles after accept; `fetched_z=0x200`, `chkz_z=0x100`.
- **Backpressure fill:** with `chkz_ready=0` and immediate responses, push 6 pixels with `DEPTH=4`.
  - Required: exactly 4 accepted, then `in_ready=0` and `zrd_req=0`.
  - After releasing `chkz_ready`, the outputs appear in order x=0..3, with data held stable while stalled.
- **Delayed responses:** 3 accepts; responses withheld for 10 cycles, then returned back-to-back.
  - Required: `chkz_valid=0` during the wait; then 3 consecutive outputs with matching `fetched_z`.
- **Simultaneous events:** an accept, a response and a dequeue in the same cycle.
  - Required: occupancy unchanged, `outstanding` unchanged, no lost or duplicated pixel.
- **Hazard (macro on):** `in_x=7` pending, then another `in_x=7`.
  - Required: the second request is stalled until the first dequeues, then issued the next cycle.
  - With the macro off, the second request is issued immediately.
- **Reset mid-operation:** assert reset with 3 entries pending.
  - Required: `chkz_valid=0` and `busy=0` at once; a following stray `zrd_rvalid` is dropped; the next pixel completes normally.
